mmio_uart_tx: RTL and testbench

Memory-mapped UART transmit controller on the processor data port. It decodes a two-word MMIO window and queues written bytes in a small TX FIFO. It serialises each byte as 8N1 on a single pin, and returns a real status word to software, so writes are paced by hardware rather than dropped. It sits beside dmem in the SoC; the SoC routes data-port reads from the window to this block.

---
 rtl/uart_pkg.sv | 12 +
 rtl/mmio_uart_tx_if.sv | 21 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 144 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status bit indices and TX FSM states
package uart_pkg;
  localparam int DATA_OFS   = 0;
  localparam int STATUS_OFS = 4;

  localparam int ST_READY = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_IDLE  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - processor data-port signals seen by the UART window
interface mmio_uart_tx_if;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_hit;
  logic        op_data_valid;
  logic [31:0] op_data_to_proc;

  modport master (
    output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    input  op_hit, op_data_valid, op_data_to_proc
  );

  modport slave (
    input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    output op_hit, op_data_valid, op_data_to_proc
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - byte FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO window decode, status register and 8N1 transmit FSM
import uart_pkg::*;

module mmio_uart_tx #(
  parameter logic [31:0] UART_IO_MM_LOC = 32'h00000054,
  parameter int          CLKS_PER_BIT   = 16,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic                clk,
  input  logic                reset,
  mmio_uart_tx_if.slave       bus,
  output logic                op_tx,
  output logic                op_busy
);
  localparam logic [31:0] DATA_ADDR   = UART_IO_MM_LOC + DATA_OFS;
  localparam logic [31:0] STATUS_ADDR = UART_IO_MM_LOC + STATUS_OFS;
  localparam int          CW          = $clog2(FIFO_DEPTH + 1);
  localparam int          BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          baud_end;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          data_wr, status_wr, overflow;
  logic [31:0]   status;
  logic          unused_bits;

  assign bus.op_hit        = (bus.ip_data_addr == DATA_ADDR) || (bus.ip_data_addr == STATUS_ADDR);
  assign bus.op_data_valid = bus.ip_data_rd && bus.op_hit;
  assign bus.op_data_to_proc = (bus.op_data_valid && bus.ip_data_addr == STATUS_ADDR) ? status : 32'h0;

  assign data_wr   = bus.ip_data_wr && (bus.ip_data_addr == DATA_ADDR) && bus.ip_data_mask[0];
  assign status_wr = bus.ip_data_wr && (bus.ip_data_addr == STATUS_ADDR);
  assign unused_bits = ^{bus.ip_data_mask[3:1], bus.ip_data_from_proc[31:8]};

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .push_data (bus.ip_data_from_proc[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status           = 32'h0;
    status[ST_READY] = (fifo_count < CW'(FIFO_DEPTH));
    status[ST_EMPTY] = fifo_empty;
    status[ST_IDLE]  = (state == IDLE) && fifo_empty;
    status[ST_OVF]   = overflow;
  end

  assign op_busy = !fifo_empty || (state != IDLE);

  // A dropped byte in the same cycle as a software clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (data_wr && fifo_full && !fifo_pop)
      overflow <= 1'b1;
    else if (status_wr && bus.ip_data_from_proc[ST_OVF])
      overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
    end
  end

  assign baud_end = (baud == BAUD_LAST);

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    fifo_pop  = 1'b0;
    op_tx     = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_head;
          baud_n   = '0;
          state_n  = START;
        end
      end
      START: begin
        op_tx = 1'b0;
        if (baud_end) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        op_tx = shift_reg[0];
        if (baud_end) begin
          baud_n  = '0;
          shift_n = shift_reg >> 1;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave with no gap.
        if (baud_end) begin
          baud_n = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_head;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized and directed checks against a frame-level model
module tb_mmio_uart_tx;
  localparam int          C      = 4;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] LOC    = 32'h00000054;
  localparam logic [31:0] SADDR  = LOC + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_tx, op_busy;
  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.UART_IO_MM_LOC(LOC), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .op_tx   (op_tx),
    .op_busy (op_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         active = 0;
  int         t = 0;
  logic [7:0] cur = 8'h0;
  bit         ovf = 0;
  int         frames = 0;
  bit         model_ok = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (q.size() < DEPTH);
    s[1] = (q.size() == 0);
    s[2] = !active && (q.size() == 0);
    s[3] = ovf;
    return s;
  endfunction

  function automatic logic model_tx();
    int b;
    if (!active) return 1'b1;
    b = t / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  always @(posedge clk) begin
    bit pop;
    if (reset) begin
      q.delete();
      active = 0;
      t = 0;
      ovf = 0;
      model_ok = 1;
    end else if (model_ok) begin
      pop = 0;
      if (!active) begin
        if (q.size() > 0) pop = 1;
      end else if (t == 10 * C - 1) begin
        if (q.size() > 0) pop = 1;
        else active = 0;
      end else begin
        t++;
      end
      if (pop) begin
        cur = q.pop_front();
        t = 0;
        active = 1;
        frames++;
      end
      if (bus.ip_data_wr && bus.ip_data_addr == LOC && bus.ip_data_mask[0]) begin
        if (q.size() < DEPTH) q.push_back(bus.ip_data_from_proc[7:0]);
        else ovf = 1;
      end else if (bus.ip_data_wr && bus.ip_data_addr == SADDR && bus.ip_data_from_proc[3]) begin
        ovf = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic        hit;
    logic [31:0] rdata;
    if (model_ok) begin
      hit = (bus.ip_data_addr == LOC) || (bus.ip_data_addr == SADDR);
      rdata = (bus.ip_data_rd && hit && bus.ip_data_addr == SADDR) ? model_status() : 32'h0;
      check("tx", 32'(op_tx), 32'(model_tx()));
      check("busy", 32'(op_busy), 32'(active || q.size() > 0));
      check("hit", 32'(bus.op_hit), 32'(hit));
      check("valid", 32'(bus.op_data_valid), 32'(bus.ip_data_rd && hit));
      check("rdata", bus.op_data_to_proc, rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    bus.ip_data_addr = addr;
    bus.ip_data_from_proc = data;
    bus.ip_data_mask = mask;
    bus.ip_data_wr = 1'b1;
    tick();
    bus.ip_data_wr = 1'b0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    bus.ip_data_addr = SADDR;
    bus.ip_data_rd = 1'b1;
    #2;
    v = bus.op_data_to_proc;
    tick();
    bus.ip_data_rd = 1'b0;
  endtask

  task automatic sample_frame(input int lead, output logic [9:0] bits);
    repeat (lead) tick();
    for (int k = 0; k < 10; k++) begin
      repeat (2) tick();
      bits[k] = op_tx;
      repeat (2) tick();
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (op_busy && n < max) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(n < max), 32'd1);
  endtask

  initial begin
    logic [31:0] st;
    logic [9:0]  bits;
    int          f0;
    int          r;

    bus.ip_data_addr = 32'h0;
    bus.ip_data_wr = 1'b0;
    bus.ip_data_mask = 4'h0;
    bus.ip_data_from_proc = 32'h0;
    bus.ip_data_rd = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    rd_status(st);
    check("reset_status", st, 32'h7);
    check("reset_tx", 32'(op_tx), 32'd1);
    check("reset_busy", 32'(op_busy), 32'd0);

    wr_bus(LOC, 32'h55, 4'hf);
    sample_frame(1, bits);
    check("frame_55", 32'(bits), 32'(10'b1010101010));
    check("after_55_busy", 32'(op_busy), 32'd0);
    rd_status(st);
    check("after_55_status", st, 32'h7);

    wr_bus(LOC, 32'h41, 4'hf);
    wr_bus(LOC, 32'h42, 4'hf);
    sample_frame(0, bits);
    check("frame_41", 32'(bits), 32'(10'b1010000010));
    sample_frame(0, bits);
    check("frame_42", 32'(bits), 32'(10'b1010000100));
    wait_idle(100);

    f0 = frames;
    for (int i = 0; i < 10; i++) wr_bus(LOC, 32'(8'h30 + i), 4'hf);
    rd_status(st);
    check("ovf_status", st, 32'h8);
    wr_bus(SADDR, 32'h8, 4'hf);
    rd_status(st);
    check("ovf_cleared", st, 32'h0);
    wait_idle(1000);
    check("ovf_frames", 32'(frames - f0), 32'd9);

    wr_bus(LOC, 32'h99, 4'b0010);
    tick();
    rd_status(st);
    check("mask_status", st, 32'h7);
    check("mask_tx", 32'(op_tx), 32'd1);

    for (int i = 0; i < 4; i++) wr_bus(LOC, 32'(8'hA0 + i), 4'hf);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_tx", 32'(op_tx), 32'd1);
    rd_status(st);
    check("abort_status", st, 32'h7);
    f0 = frames;
    repeat (60) tick();
    check("abort_busy", 32'(op_busy), 32'd0);
    check("abort_frames", 32'(frames - f0), 32'd0);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        wr_bus(($urandom_range(0, 9) == 0) ? 32'h50 : LOC, $urandom, 4'($urandom_range(0, 15)));
      end else if (r < 25) begin
        wr_bus(SADDR, $urandom, 4'hf);
      end else if (r < 45) begin
        case ($urandom_range(0, 3))
          0: bus.ip_data_addr = LOC;
          1: bus.ip_data_addr = SADDR;
          2: bus.ip_data_addr = 32'h50;
          default: bus.ip_data_addr = 32'h5C;
        endcase
        bus.ip_data_rd = 1'b1;
        tick();
        bus.ip_data_rd = 1'b0;
      end else begin
        tick();
      end
    end
    wait_idle(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
